// File: rtl/joy_pkg.sv
// ============================================================================
// Module   : joy_pkg
// Purpose  : Shared scan states, bit indices and the DB9 pin-to-vector remap.
// Revision : 1.0
// ============================================================================
`default_nettype none

package joy_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEL_HI  = 3'd1,
        SEL_LO  = 3'd2,
        RESTORE = 3'd3,
        COMMIT  = 3'd4
    } scan_state_t;

    localparam int IN_W  = 6;
    localparam int OUT_W = 8;

    // Output vector bit positions (active-low, substitute_mcu format)
    localparam int JOY_RIGHT = 0;
    localparam int JOY_LEFT  = 1;
    localparam int JOY_DOWN  = 2;
    localparam int JOY_UP    = 3;
    localparam int JOY_F1    = 4;
    localparam int JOY_F2    = 5;
    localparam int JOY_F3    = 6;
    localparam int JOY_START = 7;

    // DB9 pin positions; A/Start share the B/C pins while select is low
    localparam int PIN_UP    = 0;
    localparam int PIN_DOWN  = 1;
    localparam int PIN_LEFT  = 2;
    localparam int PIN_RIGHT = 3;
    localparam int PIN_B     = 4;
    localparam int PIN_C     = 5;
    localparam int PIN_A     = 4;
    localparam int PIN_START = 5;

    // Returns {pad_detected, joy_vector}
    function automatic logic [OUT_W:0] joy_remap(
        input logic [IN_W-1:0] hi,
        input logic [IN_W-1:0] lo,
        input logic            ext
    );
        logic [OUT_W-1:0] v;
        logic             pad;
        pad          = ext & ~lo[PIN_LEFT] & ~lo[PIN_RIGHT];
        v            = '1;
        v[JOY_RIGHT] = hi[PIN_RIGHT];
        v[JOY_LEFT]  = hi[PIN_LEFT];
        v[JOY_DOWN]  = hi[PIN_DOWN];
        v[JOY_UP]    = hi[PIN_UP];
        v[JOY_F1]    = hi[PIN_B];
        v[JOY_F2]    = hi[PIN_C];
        if (pad) begin
            v[JOY_F3]    = lo[PIN_A];
            v[JOY_START] = lo[PIN_START];
        end
        return {pad, v};
    endfunction

endpackage

`default_nettype wire

// File: rtl/joy_debounce.sv
// ============================================================================
// Module   : joy_debounce
// Purpose  : Per-port scan debouncer; output follows a candidate seen on
//            DEBOUNCE_SCANS consecutive commit strobes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module joy_debounce #(
    parameter int             W              = 9,
    parameter int             DEBOUNCE_SCANS = 3,
    parameter logic [W-1:0]   RESET_VAL      = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         commit,
    input  logic [W-1:0] raw,
    output logic [W-1:0] out
);

    localparam int             CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    logic [W-1:0]     cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     out_q, out_d;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        out_d  = out_q;
        if (commit) begin
            cand_d = raw;
            if (raw == cand_q) begin
                cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
            end else begin
                cnt_d = CNT_W'(1);
            end
            if (cnt_d == CNT_MAX) begin
                out_d = cand_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q <= RESET_VAL;
            cnt_q  <= '0;
            out_q  <= RESET_VAL;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end

    assign out = out_q;

endmodule

`default_nettype wire

// File: rtl/joy_scanner.sv
// ============================================================================
// Module   : joy_scanner
// Purpose  : Multiplexed DB9 / 3-button pad scanner feeding substitute_mcu.
//            Scan period is exactly SCAN_PERIOD+SETTLE_CYCLES+1 clocks with
//            extended off, SCAN_PERIOD+3*SETTLE_CYCLES+1 with extended on.
// Revision : 1.0
// ============================================================================
`default_nettype none

module joy_scanner
    import joy_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int SETTLE_CYCLES  = 64,
    parameter int SCAN_PERIOD    = 50000,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_PORTS*IN_W-1:0]  joy_in,
    input  logic                       extended_en,
    output logic                       joy_select,
    output logic [NUM_PORTS*OUT_W-1:0] joy_out,
    output logic [NUM_PORTS-1:0]       pad_present,
    output logic                       scan_done
);

    localparam int MAX_CNT = (SCAN_PERIOD > SETTLE_CYCLES) ? SCAN_PERIOD : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] IDLE_LAST   = CNT_W'(SCAN_PERIOD - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam int PIN_W = NUM_PORTS * IN_W;

    logic [PIN_W-1:0] sync1_q, sync2_q;
    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ext_q, ext_d;
    logic [PIN_W-1:0] hi_q, hi_d;
    logic [PIN_W-1:0] lo_q, lo_d;
    logic             sel_q, sel_d;
    logic             done_q, done_d;

    // Counter restarts on every state exit, so it never exceeds its last value
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        ext_d   = ext_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (cnt_q == IDLE_LAST) begin
                    state_d = SEL_HI;
                    cnt_d   = '0;
                    ext_d   = extended_en;
                end
            end
            SEL_HI: begin
                if (cnt_q == SETTLE_LAST) begin
                    hi_d    = sync2_q;
                    cnt_d   = '0;
                    state_d = ext_q ? SEL_LO : COMMIT;
                end
            end
            SEL_LO: begin
                if (cnt_q == SETTLE_LAST) begin
                    lo_d    = sync2_q;
                    cnt_d   = '0;
                    state_d = RESTORE;
                end
            end
            RESTORE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        sel_d  = (state_d != SEL_LO);
        done_d = (state_d == COMMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            state_q <= IDLE;
            cnt_q   <= '0;
            ext_q   <= 1'b0;
            hi_q    <= '1;
            lo_q    <= '1;
            sel_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            sync1_q <= joy_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ext_q   <= ext_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
        end
    end

    assign joy_select = sel_q;
    assign scan_done  = done_q;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [OUT_W:0] raw;
        logic [OUT_W:0] deb;

        assign raw = joy_remap(hi_q[p*IN_W +: IN_W], lo_q[p*IN_W +: IN_W], ext_q);

        joy_debounce #(
            .W              (OUT_W + 1),
            .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
            .RESET_VAL      ({1'b0, {OUT_W{1'b1}}})
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .commit (done_q),
            .raw    (raw),
            .out    (deb)
        );

        assign joy_out[p*OUT_W +: OUT_W] = deb[OUT_W-1:0];
        assign pad_present[p]            = deb[OUT_W];
    end

endmodule

`default_nettype wire

// File: tb/tb_joy_scanner.sv
// ============================================================================
// Module   : tb_joy_scanner
// Purpose  : Self-checking bench for joy_scanner (2-port and 4-port builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_joy_scanner;

    localparam int SETTLE  = 4;
    localparam int PERIOD  = 20;
    localparam int DEB     = 2;
    localparam int LEN_OFF = PERIOD + SETTLE + 1;
    localparam int LEN_ON  = PERIOD + 3 * SETTLE + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ext = 1'b0;
    logic [11:0] joy_in2;
    logic [23:0] joy_in4;
    logic        sel2, sel4, done2, done4;
    logic [15:0] out2;
    logic [31:0] out4;
    logic [1:0]  pad2;
    logic [3:0]  pad4;

    int errors = 0;
    int checks = 0;

    // Per-port pin model: hi = select-high pins, pad_m = 3-button pad, ab = {Start, A}
    logic [5:0] hi_pins [4];
    logic       pad_m   [4];
    logic [1:0] ab      [4];
    logic [5:0] lo_pins [4];

    // Reference: per-port history of raw scans; output takes a value once the
    // last DEB scans all agree on it.
    logic [8:0] hist    [4][$];
    logic [8:0] exp_vec [4];

    always #5 clk = ~clk;

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            lo_pins[p] = pad_m[p] ? {ab[p], 2'b00, hi_pins[p][1:0]} : hi_pins[p];
        end
    end

    always_comb begin
        joy_in2 = '1;
        joy_in4 = '1;
        for (int p = 0; p < 2; p++) joy_in2[6*p +: 6] = sel2 ? hi_pins[p] : lo_pins[p];
        for (int p = 0; p < 4; p++) joy_in4[6*p +: 6] = sel4 ? hi_pins[p] : lo_pins[p];
    end

    joy_scanner #(
        .NUM_PORTS(2), .SETTLE_CYCLES(SETTLE), .SCAN_PERIOD(PERIOD), .DEBOUNCE_SCANS(DEB)
    ) u_dut2 (
        .clk(clk), .reset(reset), .joy_in(joy_in2), .extended_en(ext),
        .joy_select(sel2), .joy_out(out2), .pad_present(pad2), .scan_done(done2)
    );

    joy_scanner #(
        .NUM_PORTS(4), .SETTLE_CYCLES(SETTLE), .SCAN_PERIOD(PERIOD), .DEBOUNCE_SCANS(DEB)
    ) u_dut4 (
        .clk(clk), .reset(reset), .joy_in(joy_in4), .extended_en(ext),
        .joy_select(sel4), .joy_out(out4), .pad_present(pad4), .scan_done(done4)
    );

    function automatic logic [8:0] ref_raw(input logic [5:0] hi, input logic [5:0] lo, input logic e);
        logic det;
        det = e && (lo[2] == 1'b0) && (lo[3] == 1'b0);
        return {det, det ? lo[5] : 1'b1, det ? lo[4] : 1'b1,
                hi[5], hi[4], hi[0], hi[1], hi[2], hi[3]};
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 4; p++) begin
            hist[p].delete();
            exp_vec[p] = 9'h0FF;
        end
    endtask

    task automatic model_commit();
        for (int p = 0; p < 4; p++) begin
            logic [8:0] raw;
            bit         same;
            raw = ref_raw(hi_pins[p], lo_pins[p], ext);
            hist[p].push_back(raw);
            if (hist[p].size() > DEB) void'(hist[p].pop_front());
            if (hist[p].size() == DEB) begin
                same = 1'b1;
                foreach (hist[p][i]) if (hist[p][i] != raw) same = 1'b0;
                if (same) exp_vec[p] = raw;
            end
        end
    endtask

    // Call at a negedge in the first IDLE cycle of a scan; returns at the
    // negedge after the next scan_done with the period and select-low count.
    task automatic run_scan(output int cyc, output int low, output logic d4);
        bit ok;
        ok = 1'b0; cyc = 1; low = 0; d4 = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            cyc++;
            if (!sel2) low++;
            if (done2) begin ok = 1'b1; d4 = done4; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL scan_timeout: no scan_done within 200 cycles");
        end else begin
            model_commit();
        end
        @(negedge clk);
    endtask

    task automatic set_idle_pins();
        for (int p = 0; p < 4; p++) begin
            hi_pins[p] = '1; pad_m[p] = 1'b0; ab[p] = 2'b11;
        end
    endtask

    task automatic test_reset();
        int cyc, low; logic d4;
        set_idle_pins();
        ext = 1'b0; reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({sel2, out2, pad2, done2} !== {1'b1, 16'hFFFF, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: sel=%b out=%h pad=%b done=%b, want 1 ffff 00 0", sel2, out2, pad2, done2);
        end
        checks++;
        if ({sel4, out4, pad4, done4} !== {1'b1, 32'hFFFFFFFF, 4'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state4: sel=%b out=%h pad=%b done=%b", sel4, out4, pad4, done4);
        end
        reset = 1'b0;
        model_reset();
        for (int s = 0; s < 3; s++) begin
            run_scan(cyc, low, d4);
            checks++;
            if (cyc != LEN_OFF || low != 0) begin
                errors++;
                $display("FAIL idle_timing scan%0d: period=%0d low=%0d, want %0d 0", s, cyc, low, LEN_OFF);
            end
            checks++;
            if ({out2, pad2, done2, d4} !== {16'hFFFF, 2'b00, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL idle_out scan%0d: out=%h pad=%b done_after=%b done4=%b", s, out2, pad2, done2, d4);
            end
        end
    endtask

    task automatic test_up_latency();
        int cyc, low; logic d4;
        hi_pins[0] = 6'b111110;
        run_scan(cyc, low, d4);
        checks++;
        if (out2[7:0] !== 8'hFF) begin
            errors++;
            $display("FAIL up_first_scan: out=%h want ff", out2[7:0]);
        end
        run_scan(cyc, low, d4);
        checks++;
        if (out2[7:0] !== 8'hF7) begin
            errors++;
            $display("FAIL up_second_scan: out=%h want f7", out2[7:0]);
        end
        hi_pins[0] = '1;
        run_scan(cyc, low, d4);
        run_scan(cyc, low, d4);
        checks++;
        if (out2[7:0] !== 8'hFF) begin
            errors++;
            $display("FAIL up_release: out=%h want ff", out2[7:0]);
        end
    endtask

    task automatic test_pad();
        int cyc, low; logic d4;
        ext = 1'b1;
        pad_m[1] = 1'b1; ab[1] = 2'b10;
        for (int s = 0; s < 3; s++) begin
            run_scan(cyc, low, d4);
            checks++;
            if (cyc != LEN_ON || low != SETTLE) begin
                errors++;
                $display("FAIL pad_timing scan%0d: period=%0d low=%0d, want %0d %0d", s, cyc, low, LEN_ON, SETTLE);
            end
            checks++;
            if (s == 0 && {pad2, out2} !== {2'b00, 16'hFFFF}) begin
                errors++;
                $display("FAIL pad_first_scan: pad=%b out=%h want 00 ffff", pad2, out2);
            end else if (s > 0 && {pad2, out2} !== {2'b10, 16'hBFFF}) begin
                errors++;
                $display("FAIL pad_detect scan%0d: pad=%b out=%h want 10 bfff", s, pad2, out2);
            end
        end
    endtask

    task automatic test_glitch();
        int cyc, low; logic d4;
        ext = 1'b0;
        set_idle_pins();
        run_scan(cyc, low, d4);
        run_scan(cyc, low, d4);
        for (int s = 0; s < 3; s++) begin
            hi_pins[0] = (s == 0) ? 6'b101111 : 6'b111111;
            run_scan(cyc, low, d4);
            checks++;
            if ({pad2, out2} !== {2'b00, 16'hFFFF}) begin
                errors++;
                $display("FAIL glitch scan%0d: pad=%b out=%h want 00 ffff", s, pad2, out2);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc, low; logic d4;
        bit hit;
        ext = 1'b1;
        pad_m[1] = 1'b1; ab[1] = 2'b10;
        run_scan(cyc, low, d4);
        run_scan(cyc, low, d4);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (!sel2) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL mid_reset_wait: select never went low");
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({sel2, out2, pad2, done2, out4} !== {1'b1, 16'hFFFF, 2'b00, 1'b0, 32'hFFFFFFFF}) begin
            errors++;
            $display("FAIL mid_reset_state: sel=%b out=%h pad=%b done=%b out4=%h", sel2, out2, pad2, done2, out4);
        end
        reset = 1'b0;
        model_reset();
        run_scan(cyc, low, d4);
        checks++;
        if (cyc != LEN_ON || {pad2, out2} !== {2'b00, 16'hFFFF}) begin
            errors++;
            $display("FAIL mid_reset_rescan: period=%0d pad=%b out=%h want %0d 00 ffff", cyc, pad2, out2, LEN_ON);
        end
        run_scan(cyc, low, d4);
        checks++;
        if ({pad2, out2} !== {2'b10, 16'hBFFF}) begin
            errors++;
            $display("FAIL mid_reset_recover: pad=%b out=%h want 10 bfff", pad2, out2);
        end
    endtask

    task automatic test_four_ports();
        int cyc, low; logic d4;
        ext = 1'b1;
        hi_pins[0] = 6'b111110; pad_m[0] = 1'b0; ab[0] = 2'b11;
        hi_pins[1] = 6'b111011; pad_m[1] = 1'b0; ab[1] = 2'b11;
        hi_pins[2] = 6'b011111; pad_m[2] = 1'b1; ab[2] = 2'b01;
        hi_pins[3] = 6'b110101; pad_m[3] = 1'b0; ab[3] = 2'b11;
        run_scan(cyc, low, d4);
        run_scan(cyc, low, d4);
        checks++;
        if ({pad4, out4} !== {4'b0100, 32'hFA5FFDF7}) begin
            errors++;
            $display("FAIL four_ports: pad=%b out=%h want 0100 fa5ffdf7", pad4, out4);
        end
        checks++;
        if ({pad2, out2} !== {2'b00, 16'hFDF7}) begin
            errors++;
            $display("FAIL four_ports_dut2: pad=%b out=%h want 00 fdf7", pad2, out2);
        end
    endtask

    task automatic test_random();
        int cyc, low; logic d4;
        logic e_used;
        for (int s = 0; s < 16; s++) begin
            if ($urandom_range(0, 3) == 0) ext = ~ext;
            for (int p = 0; p < 4; p++) begin
                if ($urandom_range(0, 2) == 0) begin
                    hi_pins[p] = 6'($urandom);
                    pad_m[p]   = 1'($urandom);
                    ab[p]      = 2'($urandom);
                end
            end
            e_used = ext;
            run_scan(cyc, low, d4);
            checks++;
            if (cyc != (e_used ? LEN_ON : LEN_OFF) || low != (e_used ? SETTLE : 0) || d4 !== 1'b1) begin
                errors++;
                $display("FAIL rand_timing scan%0d: period=%0d low=%0d done4=%b ext=%b", s, cyc, low, d4, e_used);
            end
            for (int p = 0; p < 4; p++) begin
                checks++;
                if ({pad4[p], out4[8*p +: 8]} !== exp_vec[p]) begin
                    errors++;
                    $display("FAIL rand_port4 scan%0d p%0d: got %h want %h", s, p, {pad4[p], out4[8*p +: 8]}, exp_vec[p]);
                end
            end
            for (int p = 0; p < 2; p++) begin
                checks++;
                if ({pad2[p], out2[8*p +: 8]} !== exp_vec[p]) begin
                    errors++;
                    $display("FAIL rand_port2 scan%0d p%0d: got %h want %h", s, p, {pad2[p], out2[8*p +: 8]}, exp_vec[p]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_latency();
        test_pad();
        test_glitch();
        test_reset_mid();
        test_four_ports();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/joy_scanner.md
Name: joy_scanner

Overview:
- Parametrised successor to the fixed two-port joystick remap in the board top level.
- Scans NUM_PORTS DB9 joystick ports through the shared multiplexed JOY_SELECT line, with 3-button Mega Drive pad support and pad detection.
- Synchronises, remaps and debounces each port into the 8-bit active-low vector format that substitute_mcu expects on its joy1..joy4 inputs.
- Sits between the board joystick pins and substitute_mcu. Runs on the system clock.

Parameters:
- NUM_PORTS, 2, number of joystick ports scanned (1..4).
- SETTLE_CYCLES, 64, clocks to wait after each joy_select edge before sampling (>=2).
- SCAN_PERIOD, 50000, idle clocks between scans (1 ms at 50 MHz).
- DEBOUNCE_SCANS, 3, consecutive identical scans required before a port output updates (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- joy_in  in  NUM_PORTS*6  raw pins, active-low, port p at [6p+5:6p]; bit0 up, 1 down, 2 left, 3 right, 4 fire B, 5 fire C (A / Start while select low).
- extended_en  in  1  1 = perform the select-low phase for 3-button pads.
- joy_select  out  1  drives board JOY_SELECT.
- joy_out  out  NUM_PORTS*8  debounced, active-low, port p at [8p+7:8p].
- pad_present  out  NUM_PORTS  1 = Mega Drive pad detected on the port at the last committed scan.
- scan_done  out  1  one-cycle pulse when a scan is committed.

Behaviour:
- Reset values: joy_select=1, joy_out all ones, pad_present=0, scan_done=0, FSM in IDLE with counters cleared. A reset asserted mid-scan aborts the scan; nothing is committed.
- joy_in passes through a 2-flop synchroniser. All samples use the synchronised value.
- FSM states:
  - IDLE: count SCAN_PERIOD clocks, then go to SEL_HI.
  - SEL_HI: joy_select=1; wait SETTLE_CYCLES, then latch hi_smp.
  - If extended_en was latched at 1 at scan start, go to SEL_LO; otherwise go to COMMIT.
  - SEL_LO: joy_select=0; wait SETTLE_CYCLES, then latch lo_smp.
  - RESTORE: joy_select=1; wait SETTLE_CYCLES, so no pad is left in the low phase.
  - COMMIT: one cycle, then back to IDLE.
- extended_en is latched on leaving IDLE. Changes during a scan do not take effect until the next scan.
- Raw remap per port (active-low), from hi_smp:
  - out[0]=hi[3], out[1]=hi[2], out[2]=hi[1], out[3]=hi[0].
  - out[4]=hi[4], out[5]=hi[5].
- Raw remap per port, select-low bits:
  - out[6] = lo[4] (A), out[7] = lo[5] (Start).
  - These apply only when the pad is detected; otherwise out[7:6]=2'b11.
- Pad detection: lo[2]==0 && lo[3]==0 in the select-low sample. Detection is 0 when extended is off.
- Debounce, per port, in COMMIT:
  - If raw == cand, cnt saturates-increments at DEBOUNCE_SCANS; otherwise cand<=raw and cnt<=1.
  - When the resulting cnt == DEBOUNCE_SCANS, joy_out[p]<=cand and pad_present[p]<=cand_pad.
  - cand_pad is debounced together with cand as one 9-bit vector.
- Update latency:
  - DEBOUNCE_SCANS=1 updates on every COMMIT.
  - A stable change appears at the DEBOUNCE_SCANS-th COMMIT after it is first sampled.
- scan_done pulses in the COMMIT cycle. joy_out is valid from the next cycle.
- Scan length in clocks: SCAN_PERIOD + SETTLE_CYCLES + 1 with extended off; SCAN_PERIOD + 3*SETTLE_CYCLES + 1 with extended on (±1 per state transition, to be fixed exactly by the implementation and documented in the header).
- Counter widths are $clog2 of the largest count + 1. No wrap in any counter.

Decomposition:
- Package joy_pkg holds:
  - typedef enum scan_state_t {IDLE, SEL_HI, SEL_LO, RESTORE, COMMIT}.
  - localparam bit indices JOY_UP/DOWN/LEFT/RIGHT/F1/F2/F3/START.
  - localparam IN_W=6, OUT_W=8.
- Sub-module joy_debounce (one per port, generate loop): candidate register, saturating counter and output register, with commit strobe input.

Test Plan:
- Bench parameters: SETTLE_CYCLES=4, SCAN_PERIOD=20, DEBOUNCE_SCANS=2.
- Reset, joy_in all ones, extended_en=0 -> joy_select stays 1; joy_out=16'hFFFF, pad_present=0 after 3 scans; scan_done once per scan.
- Port0 hi bits = 6'b111110 (up held), extended off -> joy_out[7:0]=8'hF7 at the 2nd scan_done, not the 1st.
- extended_en=1, bench models a pad on port1 (select low: left/right low, A pressed) -> joy_select low for 4 clocks per scan; pad_present=2'b10; joy_out[15:8] bit6=0, bit7=1.
- Glitch: port0 fire B low for one scan only -> joy_out[7:0] remains 8'hFF.
- Reset asserted during SEL_LO -> next cycle joy_select=1, joy_out all ones, no scan_done until a full new scan completes.
- NUM_PORTS=4 elaboration, distinct patterns per port -> each joy_out byte is independently correct, with no cross-port leakage.
